dmem_ctrl: RTL

Two-port arbiter and access sequencer in front of the single-port `dmem` data memory (14-bit byte address, 32-bit word, 4-bit byte-enable, 1-cycle registered read).
- Port m0 is the core load/store unit. Port m1 is the debug/boot loader.
- Each accepted request is turned into byte-lane enables and a replicated store word for `dmem`.
- Load data comes back aligned and sign- or zero-extended one cycle after issue. Misaligned and illegal-size requests are rejected without touching memory.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_fmt.sv | 51 +++++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem access controller: size codes, the
// alignment rule and the record carried from issue to response.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef struct packed {
    logic       owner;
    logic       is_load;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } resp_t;

  // True when the access cannot be issued: size 11 or not naturally aligned.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_bad = 1'b0;
      SIZE_H:  is_bad = off[0];
      SIZE_W:  is_bad = |off;
      default: is_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store enables/replicated data for the issuing request,
// and extraction plus sign/zero extension of the returning load word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] din_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_uns_i,
  input  logic [31:0] dout_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    we_o  = 4'b0000;
    din_o = 32'h0;
    case (st_size_i)
      SIZE_B: begin
        we_o  = 4'b0001 << st_off_i;
        din_o = {4{wdata_i[7:0]}};
      end
      SIZE_H: begin
        we_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
        din_o = {2{wdata_i[15:0]}};
      end
      SIZE_W: begin
        we_o  = 4'b1111;
        din_o = wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = dout_i >> {ld_off_i, 3'b000};
    rdata_o = 32'h0;
    case (ld_size_i)
      SIZE_B:  rdata_o = {{24{~ld_uns_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_o = {{16{~ld_uns_i & shifted[15]}}, shifted[15:0]};
      SIZE_W:  rdata_o = shifted;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin two-port front end for the single-port dmem: grants one request
// per cycle, drives dmem combinationally and returns a response one cycle later.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_resp_valid,
  output logic [31:0]       m0_resp_rdata,
  output logic              m0_resp_err,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_resp_valid,
  output logic [31:0]       m1_resp_rdata,
  output logic              m1_resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              last_grant_q, last_grant_d;
  logic              pend_q, pend_d;
  resp_t             resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              tie, gnt0, gnt1, any_gnt, sel_err;
  logic              sel_we, sel_uns;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata, st_din, ld_rdata;
  logic [3:0]        st_we;
  logic              vld, rd_ok;

  // Issue: arbitration and dmem drive, all combinational in the grant cycle
  assign tie     = m0_valid & m1_valid;
  assign gnt0    = ~rst & m0_valid & (~m1_valid | last_grant_q);
  assign gnt1    = ~rst & m1_valid & (~m0_valid | ~last_grant_q);
  assign any_gnt = gnt0 | gnt1;

  assign sel_we    = gnt1 ? m1_we       : m0_we;
  assign sel_size  = gnt1 ? m1_size     : m0_size;
  assign sel_uns   = gnt1 ? m1_unsigned : m0_unsigned;
  assign sel_addr  = gnt1 ? m1_addr     : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata    : m0_wdata;
  assign sel_err   = is_bad(sel_size, sel_addr[1:0]);

  dmem_lane_fmt u_fmt (
    .st_size_i (sel_size),
    .st_off_i  (sel_addr[1:0]),
    .wdata_i   (sel_wdata),
    .we_o      (st_we),
    .din_o     (st_din),
    .ld_size_i (resp_q.size),
    .ld_off_i  (resp_q.off),
    .ld_uns_i  (resp_q.uns),
    .dout_i    (mem_dout),
    .rdata_o   (ld_rdata)
  );

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;
  assign mem_en   = any_gnt & ~sel_err;
  assign mem_we   = (mem_en & sel_we) ? st_we : 4'b0000;
  assign mem_addr = any_gnt ? sel_addr : '0;
  assign mem_din  = any_gnt ? st_din : 32'h0;

  always_comb begin
    last_grant_d = any_gnt ? gnt1 : last_grant_q;
    pend_d       = any_gnt;
    resp_d       = resp_q;
    if (any_gnt) begin
      resp_d = '{owner: gnt1, is_load: ~sel_we, size: sel_size, uns: sel_uns,
                 off: sel_addr[1:0], err: sel_err};
    end
    cnt_d = (tie && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
    end
    resp_q <= resp_d;
  end

  // Response: one cycle after issue, masked while reset is held
  assign vld   = pend_q & ~rst;
  assign rd_ok = vld & resp_q.is_load & ~resp_q.err;

  assign m0_resp_valid = vld & ~resp_q.owner;
  assign m1_resp_valid = vld &  resp_q.owner;
  assign m0_resp_err   = vld & ~resp_q.owner & resp_q.err;
  assign m1_resp_err   = vld &  resp_q.owner & resp_q.err;
  assign m0_resp_rdata = (rd_ok & ~resp_q.owner) ? ld_rdata : 32'h0;
  assign m1_resp_rdata = (rd_ok &  resp_q.owner) ? ld_rdata : 32'h0;

  assign conflict_cnt = cnt_q;

endmodule
